// File: rtl/lf_adc_pkg.sv
// Shared widths, defaults and handshake state encoding for the LF ADC power detector.
package lf_adc_pkg;

    localparam int unsigned ADC_W            = 12;
    localparam int unsigned DEF_SAMPLE_DIV   = 1024;
    localparam int unsigned DEF_AVG_SHIFT    = 4;
    localparam int unsigned DEF_HOLD_SAMPLES = 4096;

    typedef enum logic [1:0] {
        PK_IDLE,
        PK_CLEAR,
        PK_ACK
    } pk_state_t;

endpackage

// File: rtl/lf_adc_chan_filter.sv
// One power channel: sample capture, exponential averager and decaying peak hold.
module lf_adc_chan_filter
    import lf_adc_pkg::*;
#(
    parameter int unsigned AVG_SHIFT    = DEF_AVG_SHIFT,
    parameter int unsigned HOLD_SAMPLES = DEF_HOLD_SAMPLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    input  logic             clear,
    input  logic [ADC_W-1:0] sample,
    output logic [ADC_W-1:0] avg,
    output logic [ADC_W-1:0] peak
);

    localparam int unsigned ACC_W  = ADC_W + AVG_SHIFT;
    localparam int unsigned HOLD_W = $clog2(HOLD_SAMPLES + 1);

    logic [ADC_W-1:0]  s_q;
    logic              upd_q;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [ADC_W-1:0]  peak_q, peak_d;
    logic [HOLD_W-1:0] hold_q, hold_d;

    // acc settles at most at 4095 * 2^k, so the top ADC_W bits never wrap
    always_comb begin
        acc_d = acc_q - (acc_q >> AVG_SHIFT) + ACC_W'(s_q);
    end

    // A clear beats a coincident update; the discarded sample never reaches the peak
    always_comb begin
        peak_d = peak_q;
        hold_d = hold_q;
        if (clear) begin
            peak_d = '0;
            hold_d = '0;
        end else if (upd_q) begin
            if (s_q > peak_q) begin
                peak_d = s_q;
                hold_d = '0;
            end else if (hold_q == HOLD_W'(HOLD_SAMPLES - 1)) begin
                peak_d = s_q;
                hold_d = '0;
            end else begin
                hold_d = hold_q + HOLD_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_q    <= '0;
            upd_q  <= 1'b0;
            acc_q  <= '0;
            peak_q <= '0;
            hold_q <= '0;
        end else begin
            if (s_valid) begin
                s_q <= sample;
            end
            upd_q <= s_valid;
            if (upd_q) begin
                acc_q <= acc_d;
            end
            peak_q <= peak_d;
            hold_q <= hold_d;
        end
    end

    assign avg  = acc_q[ACC_W-1 -: ADC_W];
    assign peak = peak_q;

endmodule

// File: rtl/lf_adc_power_detect.sv
// Forward/reverse power detector: sample divider, peak-clear handshake and two channel filters.
module lf_adc_power_detect
    import lf_adc_pkg::*;
#(
    parameter int unsigned SAMPLE_DIV   = DEF_SAMPLE_DIV,
    parameter int unsigned AVG_SHIFT    = DEF_AVG_SHIFT,
    parameter int unsigned HOLD_SAMPLES = DEF_HOLD_SAMPLES
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [ADC_W-1:0] ain1,
    input  logic [ADC_W-1:0] ain2,
    input  logic             pk_detect_reset,
    output logic             pk_detect_ack,
    output logic             sample_stb,
    output logic [ADC_W-1:0] fwd_avg,
    output logic [ADC_W-1:0] rev_avg,
    output logic [ADC_W-1:0] fwd_peak,
    output logic [ADC_W-1:0] rev_peak
);

    localparam int unsigned DIV_W = $clog2(SAMPLE_DIV);

    logic [DIV_W-1:0] div_q, div_d;
    logic             div_tc;
    logic             stb_q;
    pk_state_t        state_q, state_d;
    logic             ack_q;
    logic             clear_c;

    always_comb begin
        div_tc = (div_q == DIV_W'(SAMPLE_DIV - 1));
        div_d  = div_tc ? '0 : div_q + DIV_W'(1);
    end

    // Clear fires on entry to CLEAR so the peaks already read 0 while in CLEAR
    always_comb begin
        state_d = state_q;
        clear_c = 1'b0;
        case (state_q)
            PK_IDLE: begin
                if (pk_detect_reset) begin
                    state_d = PK_CLEAR;
                    clear_c = 1'b1;
                end
            end
            PK_CLEAR: state_d = PK_ACK;
            PK_ACK: begin
                if (!pk_detect_reset) begin
                    state_d = PK_IDLE;
                end
            end
            default: state_d = PK_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            div_q   <= '0;
            stb_q   <= 1'b0;
            state_q <= PK_IDLE;
            ack_q   <= 1'b0;
        end else begin
            div_q   <= div_d;
            stb_q   <= div_tc;
            state_q <= state_d;
            ack_q   <= (state_d == PK_ACK);
        end
    end

    assign sample_stb    = stb_q;
    assign pk_detect_ack = ack_q;

    lf_adc_chan_filter #(
        .AVG_SHIFT   (AVG_SHIFT),
        .HOLD_SAMPLES(HOLD_SAMPLES)
    ) u_fwd (
        .clk    (clock),
        .rst_n  (reset_n),
        .s_valid(stb_q),
        .clear  (clear_c),
        .sample (ain1),
        .avg    (fwd_avg),
        .peak   (fwd_peak)
    );

    lf_adc_chan_filter #(
        .AVG_SHIFT   (AVG_SHIFT),
        .HOLD_SAMPLES(HOLD_SAMPLES)
    ) u_rev (
        .clk    (clock),
        .rst_n  (reset_n),
        .s_valid(stb_q),
        .clear  (clear_c),
        .sample (ain2),
        .avg    (rev_avg),
        .peak   (rev_peak)
    );

endmodule

// File: tb/tb_lf_adc_power_detect.sv
// Scoreboard bench for lf_adc_power_detect: averager, peak hold/decay and clear handshake.
module tb_lf_adc_power_detect;

    localparam int DIV  = 64;
    localparam int K    = 4;
    localparam int HOLD = 8;

    typedef struct packed {
        logic [11:0] fa;
        logic [11:0] fp;
        logic [11:0] ra;
        logic [11:0] rp;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_n, reset8_n, pk_req;
    logic [11:0] ain1, ain2;
    logic [11:0] ain_hi = 12'hFFF;
    logic [11:0] ain_lo = 12'h000;
    logic        req_off = 1'b0;
    logic        ack, stb;
    logic [11:0] fwd_avg, rev_avg, fwd_peak, rev_peak;
    logic        ack8, stb8;
    logic [11:0] fwd_avg8, rev_avg8, fwd_peak8, rev_peak8;

    int   total = 0;
    int   bad   = 0;
    exp_t q[$];
    int   m_acc[2];
    int   m_peak[2];
    int   m_hold[2];
    int   cnt8;

    always #5 clock = ~clock;

    lf_adc_power_detect #(.SAMPLE_DIV(DIV), .AVG_SHIFT(K), .HOLD_SAMPLES(HOLD)) u_dut (
        .clock(clock), .reset_n(reset_n), .ain1(ain1), .ain2(ain2),
        .pk_detect_reset(pk_req), .pk_detect_ack(ack), .sample_stb(stb),
        .fwd_avg(fwd_avg), .rev_avg(rev_avg), .fwd_peak(fwd_peak), .rev_peak(rev_peak)
    );

    lf_adc_power_detect #(.SAMPLE_DIV(DIV), .AVG_SHIFT(8), .HOLD_SAMPLES(4096)) u_dut8 (
        .clock(clock), .reset_n(reset8_n), .ain1(ain_hi), .ain2(ain_lo),
        .pk_detect_reset(req_off), .pk_detect_ack(ack8), .sample_stb(stb8),
        .fwd_avg(fwd_avg8), .rev_avg(rev_avg8), .fwd_peak(fwd_peak8), .rev_peak(rev_peak8)
    );

    always @(posedge clock) begin
        if (!reset8_n) cnt8 <= 0;
        else if (stb8) cnt8 <= cnt8 + 1;
    end

    function automatic void model_reset();
        for (int c = 0; c < 2; c++) begin
            m_acc[c] = 0; m_peak[c] = 0; m_hold[c] = 0;
        end
    endfunction

    function automatic void model_clear();
        for (int c = 0; c < 2; c++) begin
            m_peak[c] = 0; m_hold[c] = 0;
        end
    endfunction

    function automatic void model_update(input logic [11:0] s1, input logic [11:0] s2, input bit clr);
        int s[2];
        s[0] = int'(s1);
        s[1] = int'(s2);
        for (int c = 0; c < 2; c++) begin
            m_acc[c] = m_acc[c] - (m_acc[c] >> K) + s[c];
            if (clr) begin
                m_peak[c] = 0; m_hold[c] = 0;
            end else if (s[c] > m_peak[c]) begin
                m_peak[c] = s[c]; m_hold[c] = 0;
            end else if (m_hold[c] == HOLD - 1) begin
                m_peak[c] = s[c]; m_hold[c] = 0;
            end else begin
                m_hold[c] = m_hold[c] + 1;
            end
        end
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.fa = 12'(m_acc[0] >> K);
        e.fp = 12'(m_peak[0]);
        e.ra = 12'(m_acc[1] >> K);
        e.rp = 12'(m_peak[1]);
        return e;
    endfunction

    function automatic logic [11:0] model_k8(input int n);
        longint acc = 0;
        for (int i = 0; i < n; i++) acc = acc - (acc >> 8) + 4095;
        return 12'(acc >> 8);
    endfunction

    // Leaves the caller on the negedge of the strobe cycle; a missing strobe counts as a failure
    task automatic wait_stb();
        bit ok = 1'b0;
        for (int i = 0; i < 2 * DIV; i++) begin
            @(negedge clock);
            if (stb) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL stb_timeout: no sample_stb within %0d cycles", 2 * DIV);
        end
    endtask

    // Drives one sample, pushes its expectation, returns at the cycle the result is visible
    task automatic do_sample(input logic [11:0] a1, input logic [11:0] a2);
        ain1 = a1;
        ain2 = a2;
        model_update(a1, a2, 1'b0);
        q.push_back(model_out());
        wait_stb();
        @(negedge clock);
        @(negedge clock);
    endtask

    task automatic reset_dut();
        reset_n = 1'b0;
        pk_req  = 1'b0;
        ain1    = '0;
        ain2    = '0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        model_reset();
        q.delete();
    endtask

    task automatic test_reset();
        reset8_n = 1'b0;
        reset_dut();
        reset8_n = 1'b1;
        @(negedge clock);
        total++;
        if ({fwd_avg, rev_avg, fwd_peak, rev_peak, ack, stb} !== 50'd0) begin
            bad++;
            $display("FAIL reset_state: got %h want 0", {fwd_avg, rev_avg, fwd_peak, rev_peak, ack, stb});
        end
    endtask

    task automatic test_average();
        exp_t e, o;
        logic [11:0] mx = '0;
        for (int i = 0; i < 200; i++) begin
            do_sample(12'h800, 12'h100);
            e = q.pop_front();
            o = {fwd_avg, fwd_peak, rev_avg, rev_peak};
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL avg_sample%0d: got %h want %h", i, o, e);
            end
            if (i == 0) begin
                total++;
                if (fwd_avg !== 12'h080 || fwd_peak !== 12'h800) begin
                    bad++;
                    $display("FAIL avg_first: got avg=%h peak=%h want 080/800", fwd_avg, fwd_peak);
                end
            end
            if (fwd_avg > mx) mx = fwd_avg;
        end
        total++;
        if (fwd_avg < 12'h7F0 || mx > 12'h800) begin
            bad++;
            $display("FAIL avg_settle: got avg=%h max=%h want >=7F0 and max<=800", fwd_avg, mx);
        end
    endtask

    task automatic test_peak_decay();
        exp_t e, o;
        int held = 0;
        reset_dut();
        for (int i = 0; i < 16; i++) begin
            do_sample(12'h000, (i < 3) ? 12'h100 : (i == 3) ? 12'hFFF : 12'h200);
            e = q.pop_front();
            o = {fwd_avg, fwd_peak, rev_avg, rev_peak};
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL peak_sample%0d: got %h want %h", i, o, e);
            end
            if (i >= 3 && rev_peak === 12'hFFF) held++;
        end
        total++;
        if (held != 8 || rev_peak !== 12'h200) begin
            bad++;
            $display("FAIL peak_hold: got held=%0d peak=%h want 8 / 200", held, rev_peak);
        end
    endtask

    task automatic test_handshake();
        exp_t e, o;
        int acks = 0, first = -1, last = -1;
        reset_dut();
        do_sample(12'hABC, 12'h123);
        e = q.pop_front();
        o = {fwd_avg, fwd_peak, rev_avg, rev_peak};
        total++;
        if (o !== e) begin
            bad++;
            $display("FAIL hs_preload: got %h want %h", o, e);
        end
        pk_req = 1'b1;
        model_clear();
        @(negedge clock);
        total++;
        if (fwd_peak !== 12'h000 || rev_peak !== 12'h000 || ack !== 1'b0) begin
            bad++;
            $display("FAIL hs_clear: got peaks=%h/%h ack=%b want 0/0 ack 0", fwd_peak, rev_peak, ack);
        end
        for (int c = 2; c <= 13; c++) begin
            @(negedge clock);
            if (ack) begin
                acks++;
                if (first < 0) first = c;
                last = c;
            end
            if (c == 10) pk_req = 1'b0;
        end
        total++;
        if (first != 2 || acks != 9 || last != 10) begin
            bad++;
            $display("FAIL hs_ack_window: got first=%0d n=%0d last=%0d want 2/9/10", first, acks, last);
        end
        pk_req = 1'b1;
        model_clear();
        do_sample(12'h321, 12'h111);
        e = q.pop_front();
        o = {fwd_avg, fwd_peak, rev_avg, rev_peak};
        total++;
        if (o !== e || ack !== 1'b1) begin
            bad++;
            $display("FAIL hs_single_clear: got %h ack=%b want %h ack=1", o, ack, e);
        end
        pk_req = 1'b0;
        @(negedge clock);
        @(negedge clock);
        total++;
        if (ack !== 1'b0) begin
            bad++;
            $display("FAIL hs_ack_drop: got %b want 0", ack);
        end
    endtask

    task automatic test_clear_collision();
        exp_t e, o;
        bit seen = 1'b0;
        ain1 = 12'hFFF;
        ain2 = 12'hFFF;
        wait_stb();
        @(negedge clock);
        pk_req = 1'b1;
        model_update(12'hFFF, 12'hFFF, 1'b1);
        q.push_back(model_out());
        @(negedge clock);
        e = q.pop_front();
        o = {fwd_avg, fwd_peak, rev_avg, rev_peak};
        total++;
        if (o !== e) begin
            bad++;
            $display("FAIL collide_clear: got %h want %h", o, e);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (ack) begin
                seen = 1'b1;
                break;
            end
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL collide_ack: got ack=0 want 1 within 8 cycles");
        end
        pk_req = 1'b0;
        @(negedge clock);
        @(negedge clock);
        do_sample(12'h400, 12'h300);
        e = q.pop_front();
        o = {fwd_avg, fwd_peak, rev_avg, rev_peak};
        total++;
        if (o !== e || fwd_peak !== 12'h400) begin
            bad++;
            $display("FAIL collide_reestablish: got %h want %h", o, e);
        end
    endtask

    task automatic test_reset_in_ack();
        bit seen = 1'b0;
        pk_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (ack) begin
                seen = 1'b1;
                break;
            end
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL rst_ack_wait: got ack=0 want 1 within 8 cycles");
        end
        reset_n = 1'b0;
        @(negedge clock);
        total++;
        if ({fwd_avg, rev_avg, fwd_peak, rev_peak, ack, stb} !== 50'd0) begin
            bad++;
            $display("FAIL rst_outputs: got %h want 0", {fwd_avg, rev_avg, fwd_peak, rev_peak, ack, stb});
        end
        reset_n = 1'b1;
        model_reset();
        q.delete();
        @(negedge clock);
        total++;
        if (ack !== 1'b0) begin
            bad++;
            $display("FAIL rst_clear_phase: got ack=%b want 0", ack);
        end
        @(negedge clock);
        total++;
        if (ack !== 1'b1) begin
            bad++;
            $display("FAIL rst_new_ack: got ack=%b want 1", ack);
        end
        pk_req = 1'b0;
        @(negedge clock);
        @(negedge clock);
    endtask

    task automatic test_saturate_k8();
        int gap = 0;
        bit got = 1'b0;
        logic [11:0] snap;
        for (int i = 0; i < 2 * DIV && !stb8; i++) @(negedge clock);
        snap = fwd_avg8;
        for (int i = 1; i <= 2 * DIV; i++) begin
            @(negedge clock);
            if (stb8) begin
                gap = i;
                break;
            end
        end
        total++;
        if (gap != DIV) begin
            bad++;
            $display("FAIL stb_spacing: got %0d want %0d", gap, DIV);
        end
        for (int i = 0; i < 1100 * DIV; i++) begin
            if (cnt8 >= 1000) begin
                got = 1'b1;
                break;
            end
            @(negedge clock);
        end
        @(negedge clock);
        total++;
        if (!got || cnt8 != 1000 || fwd_avg8 !== model_k8(1000) || fwd_peak8 !== 12'hFFF) begin
            bad++;
            $display("FAIL k8_converge: got n=%0d avg=%h peak=%h want 1000 avg=%h peak=fff",
                     cnt8, fwd_avg8, fwd_peak8, model_k8(1000));
        end
        total++;
        if (fwd_avg8 <= snap || rev_avg8 !== 12'h000) begin
            bad++;
            $display("FAIL k8_no_wrap: got avg=%h earlier=%h rev=%h want rising, rev 0", fwd_avg8, snap, rev_avg8);
        end
    endtask

    initial begin
        test_reset();
        test_average();
        test_peak_decay();
        test_handshake();
        test_clear_collision();
        test_reset_in_ack();
        test_saturate_k8();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
